ie_stage: RTL and testbench
===========================

IE_STAGE -- requirements
Module: ie_stage

Interface
REQ-001 The block SHALL have exactly one clock, `clk`, input, 1 bit, rising-edge active.
REQ-002 The block SHALL have reset `rst`, input, 1 bit, asynchronous and active-high.
REQ-003 `r1` SHALL be an input, 32 bits: register-file read data 1.
REQ-004 `r2` SHALL be an input, 32 bits: register-file read data 2.
REQ-005 `Imm` SHALL be an input, 32 bits: sign-extended immediate.
REQ-006 `PCp` SHALL be an input, 32 bits: PC of the current instruction.
REQ-007 `ALUOp` SHALL be an input, 4 bits: ALU operation select.
REQ-008 `ALUSrc1` SHALL be an input, 1 bit: 1 selects `r1`, 0 selects `PCp` as operand A.
REQ-009 `ALUSrc2` SHALL be an input, 1 bit: 1 selects `r2`, 0 selects `Imm` as operand B.
REQ-010 `b_control` SHALL be an input, 3 bits: branch condition select.
REQ-011 `ExecResult` SHALL be an output, 32 bits: registered ALU result.
REQ-012 `zero` SHALL be an output, 1 bit: registered flag, asserted when the ALU result equals 0.
REQ-013 `b_sel` SHALL be an output, 1 bit: registered branch-taken flag, sent to IF.

Function
REQ-014 The ALU SHALL compute combinationally on A = ALUSrc1 ? r1 : PCp and B = ALUSrc2 ? r2 : Imm.
REQ-015 `ALUOp` encoding SHALL be:
- 0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT (signed), 0100 SLTU
- 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND, 1010 PASS_B
- 1011..1111 produce result 0.
REQ-016 ADD and SUB SHALL be modulo 2^32 with the carry discarded; shifts SHALL use B[4:0] only; SLT/SLTU SHALL return 32'h0 or 32'h1.
REQ-017 The branch compare SHALL always use `r1` vs `r2`, independent of the ALUSrc muxes.
REQ-018 `b_control` encoding SHALL be:
- 000 none (taken = 0), 001 BEQ, 010 BNE, 011 BLT (signed), 100 BGE (signed)
- 101 BLTU, 110 BGEU, 111 unconditional (taken = 1).
REQ-019 On each rising `clk`, `ExecResult`, `zero` and `b_sel` SHALL load the current ALU result, the result==0 flag and the taken flag; latency is 1 cycle, with no stall or handshake.
REQ-020 There SHALL be no other state; a new operation is accepted every cycle.

Reset
REQ-021 While `rst` = 1, `ExecResult` SHALL be 32'h0, `zero` 0 and `b_sel` 0, immediately and independent of `clk`.
REQ-022 Reset asserted mid-operation SHALL discard the pending result; the first capture occurs at the first rising `clk` after `rst` deasserts.

Structure
REQ-023 The ALUOp and b_control encodings SHALL be enums in a shared package `riscv_pkg`, together with the constant XLEN = 32.
REQ-024 The combinational ALU SHALL be one sub-module named `alu` (inputs A, B, ALUOp; output result).
REQ-025 Branch compare, operand muxes and output registers SHALL reside in `ie_stage`.

Verification
REQ-026 ALUOp=0000, ALUSrc1=1, ALUSrc2=1, r1=BABEFACE, r2=DEADBEEF, b_control=000 -> after 1 clk: ExecResult=996CB9BD, zero=0, b_sel=0.
REQ-027 ALUSrc1=0, ALUSrc2=0, PCp=4, Imm=10, r1=C, r2=8, b_control=010 (BNE) -> after 1 clk: ExecResult=14, b_sel=1; with r1=r2=8 -> b_sel=0.
REQ-028 ALUSrc1=1, ALUSrc2=0, r1=BABEFACE, Imm=10, ADD -> after 1 clk: ExecResult=BABEFADE.
REQ-029 SUB with r1=r2=5 -> ExecResult=0, zero=1; BEQ with the same operands -> b_sel=1.
REQ-030 SRA r1=80000000, r2=4 -> F8000000; SLT r1=FFFFFFFF, r2=1 -> 1; SLTU with the same operands -> 0; BLTU with the same operands -> b_sel=0.
REQ-031 Assert `rst` between clock edges after a nonzero result -> all outputs 0 immediately; outputs hold 0 until the first clk edge after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V execute-stage definitions: datapath width, ALU and branch encodings.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_SLL   = 4'b0010,
        ALU_SLT   = 4'b0011,
        ALU_SLTU  = 4'b0100,
        ALU_XOR   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_OR    = 4'b1000,
        ALU_AND   = 4'b1001,
        ALU_PASSB = 4'b1010
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_NONE   = 3'b000,
        BR_EQ     = 3'b001,
        BR_NE     = 3'b010,
        BR_LT     = 3'b011,
        BR_GE     = 3'b100,
        BR_LTU    = 3'b101,
        BR_GEU    = 3'b110,
        BR_ALWAYS = 3'b111
    } br_ctrl_e;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; undefined opcodes yield zero.
module alu
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [3:0]      ALUOp,
    output logic [XLEN-1:0] result
);

    logic [4:0] shamt;

    assign shamt = B[4:0];

    // NOTE: assign the default first so every path drives result and no latch is inferred.
    always_comb begin
        result = '0;
        case (ALUOp)
            ALU_ADD:   result = A + B;
            ALU_SUB:   result = A - B;
            ALU_SLL:   result = A << shamt;
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, $signed(A) < $signed(B)};
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, A < B};
            ALU_XOR:   result = A ^ B;
            ALU_SRL:   result = A >> shamt;
            ALU_SRA:   result = $signed(A) >>> shamt;
            ALU_OR:    result = A | B;
            ALU_AND:   result = A & B;
            ALU_PASSB: result = B;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/ie_stage.sv
// Execute stage: operand muxing, ALU, branch resolution and one-cycle output register.
module ie_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] r1,
    input  logic [XLEN-1:0] r2,
    input  logic [XLEN-1:0] Imm,
    input  logic [XLEN-1:0] PCp,
    input  logic [3:0]      ALUOp,
    input  logic            ALUSrc1,
    input  logic            ALUSrc2,
    input  logic [2:0]      b_control,
    output logic [XLEN-1:0] ExecResult,
    output logic            zero,
    output logic            b_sel
);

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_result;
    logic            taken;

    assign op_a = ALUSrc1 ? r1 : PCp;
    assign op_b = ALUSrc2 ? r2 : Imm;

    alu u_alu (
        .A      (op_a),
        .B      (op_b),
        .ALUOp  (ALUOp),
        .result (alu_result)
    );

    // Branches always compare the raw register operands, never the muxed ALU inputs.
    always_comb begin
        taken = 1'b0;
        case (b_control)
            BR_NONE:   taken = 1'b0;
            BR_EQ:     taken = (r1 == r2);
            BR_NE:     taken = (r1 != r2);
            BR_LT:     taken = ($signed(r1) <  $signed(r2));
            BR_GE:     taken = ($signed(r1) >= $signed(r2));
            BR_LTU:    taken = (r1 <  r2);
            BR_GEU:    taken = (r1 >= r2);
            BR_ALWAYS: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ExecResult <= '0;
            zero       <= 1'b0;
            b_sel      <= 1'b0;
        end else begin
            ExecResult <= alu_result;
            zero       <= (alu_result == '0);
            b_sel      <= taken;
        end
    end

endmodule

// File: tb/tb_ie_stage.sv
// Directed self-checking bench for ie_stage with hand-computed expected values.
module tb_ie_stage;

    logic        clk;
    logic        rst;
    logic [31:0] r1, r2, Imm, PCp;
    logic [3:0]  ALUOp;
    logic        ALUSrc1, ALUSrc2;
    logic [2:0]  b_control;
    logic [31:0] ExecResult;
    logic        zero;
    logic        b_sel;

    int n_cmp  = 0;
    int n_fail = 0;

    ie_stage dut (
        .clk        (clk),
        .rst        (rst),
        .r1         (r1),
        .r2         (r2),
        .Imm        (Imm),
        .PCp        (PCp),
        .ALUOp      (ALUOp),
        .ALUSrc1    (ALUSrc1),
        .ALUSrc2    (ALUSrc2),
        .b_control  (b_control),
        .ExecResult (ExecResult),
        .zero       (zero),
        .b_sel      (b_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] res, input logic z, input logic b);
        check({tag, ".ExecResult"}, ExecResult, res);
        check({tag, ".zero"}, {31'b0, zero}, {31'b0, z});
        check({tag, ".b_sel"}, {31'b0, b_sel}, {31'b0, b});
    endtask

    // Apply one operation, clock it in, then sample 1 time unit after the edge.
    task automatic run_op(input logic s1, input logic s2, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] op,
                          input logic [2:0] bc);
        ALUSrc1   = s1;
        ALUSrc2   = s2;
        r1        = a;
        r2        = b;
        Imm       = imm;
        PCp       = pc;
        ALUOp     = op;
        b_control = bc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        r1 = '0; r2 = '0; Imm = '0; PCp = '0;
        ALUOp = 4'b0000; ALUSrc1 = 1'b1; ALUSrc2 = 1'b1; b_control = 3'b000;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        run_op(1, 1, 32'hBABEFACE, 32'hDEADBEEF, 32'h0, 32'h0, 4'b0000, 3'b000);
        check_all("add_rr", 32'h996CB9BD, 1'b0, 1'b0);

        run_op(0, 0, 32'hC, 32'h8, 32'h10, 32'h4, 4'b0000, 3'b010);
        check_all("add_pc_imm_bne", 32'h14, 1'b0, 1'b1);
        run_op(0, 0, 32'h8, 32'h8, 32'h10, 32'h4, 4'b0000, 3'b010);
        check_all("bne_equal", 32'h14, 1'b0, 1'b0);

        run_op(1, 0, 32'hBABEFACE, 32'h0, 32'h10, 32'h0, 4'b0000, 3'b000);
        check_all("add_r1_imm", 32'hBABEFADE, 1'b0, 1'b0);

        run_op(1, 1, 32'h5, 32'h5, 32'h0, 32'h0, 4'b0001, 3'b001);
        check_all("sub_zero_beq", 32'h0, 1'b1, 1'b1);

        run_op(1, 1, 32'h80000000, 32'h4, 32'h0, 32'h0, 4'b0111, 3'b000);
        check_all("sra", 32'hF8000000, 1'b0, 1'b0);
        run_op(1, 1, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 4'b0011, 3'b011);
        check_all("slt_blt", 32'h1, 1'b0, 1'b1);
        run_op(1, 1, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 4'b0100, 3'b101);
        check_all("sltu_bltu", 32'h0, 1'b1, 1'b0);
        run_op(1, 1, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 4'b0000, 3'b100);
        check_all("add_wrap_bge", 32'h0, 1'b1, 1'b0);
        run_op(1, 1, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 4'b0000, 3'b110);
        check_all("bgeu", 32'h0, 1'b1, 1'b1);

        // Shift amounts use only B[4:0]: 0x24 shifts by 4.
        run_op(1, 1, 32'h80000001, 32'h24, 32'h0, 32'h0, 4'b0110, 3'b000);
        check_all("srl_shamt", 32'h08000000, 1'b0, 1'b0);
        run_op(1, 1, 32'h80000001, 32'h24, 32'h0, 32'h0, 4'b0010, 3'b000);
        check_all("sll_shamt", 32'h00000010, 1'b0, 1'b0);
        run_op(1, 1, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0, 4'b0101, 3'b000);
        check_all("xor", 32'h0FF00FF0, 1'b0, 1'b0);
        run_op(1, 1, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0, 4'b1000, 3'b000);
        check_all("or", 32'hFFF0FFF0, 1'b0, 1'b0);
        run_op(1, 1, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'h0, 4'b1001, 3'b000);
        check_all("and", 32'hF000F000, 1'b0, 1'b0);
        run_op(1, 0, 32'h1234, 32'h1234, 32'hCAFE0001, 32'h0, 4'b1010, 3'b111);
        check_all("passb_always", 32'hCAFE0001, 1'b0, 1'b1);
        run_op(1, 1, 32'h1234, 32'h5678, 32'h0, 32'h0, 4'b1011, 3'b000);
        check_all("op_undef", 32'h0, 1'b1, 1'b0);

        // Mid-cycle reset after a nonzero result clears outputs without a clock edge.
        run_op(1, 1, 32'h11111111, 32'h22222222, 32'h0, 32'h0, 4'b0000, 3'b111);
        check_all("pre_reset", 32'h33333333, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_all("async_reset", 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all("reset_held", 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all("after_release", 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all("first_capture", 32'h33333333, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
